capture_sequencer: RTL

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/mso_pkg.sv | 28 ++
 rtl/mso_counter.sv | 40 ++++
 rtl/capture_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mso_pkg
// Description : Shared encodings for the capture sequencer and trigger hub.
// Revision    : 1.0 - initial release
// ============================================================================
package mso_pkg;

  // Trigger hub state as reported on trigger_state
  typedef enum logic [1:0] {
    TRIG_DISARMED  = 2'd0,
    TRIG_ARMED     = 2'd1,
    TRIG_TRIGGERED = 2'd2,
    TRIG_CLEARED   = 2'd3
  } trig_state_t;

  // Capture sequencer states, visible externally on seq_state
  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_PRE       = 3'd1,
    SEQ_ARMING    = 3'd2,
    SEQ_WAIT_TRIG = 3'd3,
    SEQ_POST      = 3'd4,
    SEQ_DONE      = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mso_counter.sv
`default_nettype none
// ============================================================================
// Module      : mso_counter
// Description : Write counter with clear, increment and a terminal-count flag
//               that fires on the increment that lands on the target value.
// Revision    : 1.0 - initial release
// ============================================================================
module mso_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] target,
  output logic             hit
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_inc;

  assign count_inc = count + ONE;
  // Terminal count is reached by this cycle's increment, not the stored value
  assign hit       = inc && (count_inc == target);

  // Count register: clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer
// Description : Sequences a pre-trigger fill, trigger arming, circular capture
//               while waiting for the trigger and a post-trigger fill.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer
  import mso_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sample_valid,
  input  logic [ADDR_WIDTH-1:0] pre_count,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic [1:0]            trigger_state,
  output logic                  arm,
  output logic                  trig_reset,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            seq_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t            state;
  seq_state_t            next_state;
  logic [ADDR_WIDTH-1:0] pre_lat;
  logic [ADDR_WIDTH-1:0] post_lat;
  logic                  abort_taken;
  logic                  start_capture;
  logic                  trig_seen;
  logic                  pre_inc;
  logic                  post_inc;
  logic                  pre_hit;
  logic                  post_hit;
  logic                  trig_reset_next;

  assign seq_state = state;

  // Pre-trigger write counter
  mso_counter #(.WIDTH(ADDR_WIDTH)) u_pre_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_capture),
    .inc    (pre_inc),
    .target (pre_lat),
    .hit    (pre_hit)
  );

  // Post-trigger write counter; the write on the trigger cycle is sample 1
  mso_counter #(.WIDTH(ADDR_WIDTH)) u_post_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_capture),
    .inc    (post_inc),
    .target (post_lat),
    .hit    (post_hit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEQ_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; abort outranks every other transition
  always_comb begin
    next_state      = state;
    arm             = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    wr_en           = 1'b0;
    abort_taken     = abort && (state != SEQ_IDLE);
    start_capture   = 1'b0;
    trig_seen       = 1'b0;
    pre_inc         = 1'b0;
    post_inc        = 1'b0;

    case (state)
      SEQ_IDLE, SEQ_DONE: begin
        done = (state == SEQ_DONE);
        if (start && !abort_taken) begin
          start_capture = 1'b1;
          next_state    = (pre_count == '0) ? SEQ_ARMING : SEQ_PRE;
        end
      end
      SEQ_PRE: begin
        busy    = 1'b1;
        wr_en   = sample_valid;
        pre_inc = sample_valid;
        if (pre_hit) next_state = SEQ_ARMING;
      end
      SEQ_ARMING: begin
        busy       = 1'b1;
        arm        = 1'b1;
        next_state = SEQ_WAIT_TRIG;
      end
      SEQ_WAIT_TRIG: begin
        busy      = 1'b1;
        wr_en     = sample_valid;
        trig_seen = (trigger_state == TRIG_TRIGGERED) && !abort_taken;
        post_inc  = trig_seen && sample_valid;
        if (trig_seen) begin
          next_state = ((post_lat == '0) || post_hit) ? SEQ_DONE : SEQ_POST;
        end
      end
      SEQ_POST: begin
        busy     = 1'b1;
        wr_en    = sample_valid;
        post_inc = sample_valid;
        if (post_hit) next_state = SEQ_DONE;
      end
      default: next_state = SEQ_IDLE;
    endcase

    if (abort_taken) next_state = SEQ_IDLE;

    trig_reset_next = abort_taken ||
                      ((next_state == SEQ_DONE) && (state != SEQ_DONE));
  end

  // Capture datapath: latched counts, write pointer, trigger point, reset pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_lat    <= '0;
      post_lat   <= '0;
      wr_addr    <= '0;
      trig_addr  <= '0;
      trig_reset <= 1'b0;
    end else begin
      if (start_capture) begin
        pre_lat  <= pre_count;
        post_lat <= post_count;
        wr_addr  <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + ADDR_ONE;
      end
      if (trig_seen) trig_addr <= wr_addr;
      trig_reset <= trig_reset_next;
    end
  end

endmodule
`default_nettype wire
